imem_boot_loader: RTL

- Boot-time loader upstream of the SPRAM-backed RISC-V instruction memory. SPRAM cannot be initialised at configuration, so this block fills it at boot.
- Accepts a framed byte stream from a UART/SPI receiver over a valid/ready handshake.
- Assembles little-endian 32-bit words and drives the instruction memory write port (addr, wr_en, data_in).
- Holds the core off via busy/done until the image is written and its checksum is verified.

---
 rtl/imem_boot_loader.sv | 134 +++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
`timescale 1ns/1ps
// Boot loader: receives a framed byte stream (length, payload, checksum) and
// writes little-endian 32-bit words into the SPRAM instruction memory.
module imem_boot_loader #(
  parameter int ADDR_W    = 14,
  parameter int MAX_WORDS = 16384
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_wr_en,
  output logic [31:0]       imem_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   ww_q, ww_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        lane_q, lane_d;
  logic [7:0]        csum_q, csum_d;

  logic        xfer;
  logic [31:0] n_ext;
  logic [ADDR_W:0] ww_inc;
  logic [7:0]  csum_sum;

  assign in_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                    (state_q == S_DATA)   || (state_q == S_CSUM);
  assign xfer     = in_valid & in_ready;
  assign n_ext    = {16'h0000, in_byte, len_lo_q};
  assign ww_inc   = ww_q + 1'b1;
  assign csum_sum = csum_q + in_byte;

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    ww_d     = ww_q;
    addr_d   = addr_q;
    data_d   = data_q;
    lane_d   = lane_q;
    csum_d   = csum_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_LO;
          ww_d    = '0;
          addr_d  = '0;
          lane_d  = '0;
          csum_d  = '0;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_lo_d = in_byte;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          if (n_ext > MAX_WORDS) begin
            state_d = S_ERR;
          end else begin
            len_d   = n_ext[ADDR_W:0];
            state_d = (n_ext == 32'd0) ? S_CSUM : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          data_d[{lane_q, 3'b000} +: 8] = in_byte;
          csum_d = csum_sum;
          lane_d = lane_q + 1'b1;
          if (lane_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // Address and count advance after the strobe so the write sees the old address.
        ww_d    = ww_inc;
        addr_d  = addr_q + 1'b1;
        state_d = (ww_inc == len_q) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (xfer) state_d = (csum_sum == 8'h00) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      len_lo_q <= '0;
      len_q    <= '0;
      ww_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      lane_q   <= '0;
      csum_q   <= '0;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      len_q    <= len_d;
      ww_q     <= ww_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      lane_q   <= lane_d;
      csum_q   <= csum_d;
    end
  end

  assign imem_addr     = addr_q;
  assign imem_data     = data_q;
  assign imem_wr_en    = (state_q == S_WRITE);
  assign words_written = ww_q;
  assign busy          = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  assign done          = (state_q == S_DONE);
  assign error         = (state_q == S_ERR);

endmodule
